serial_link_raw_mode_capture: RTL and testbench
===============================================

// Module: serial_link_raw_mode_capture
// PURPOSE
//  Receive-side counterpart of the data link raw-mode TX FIFO: captures raw phy words from one selected channel
//  into a readable FIFO for link calibration/debug. Optional trigger: capture starts at a masked pattern match.
//  Sits between the CDC RX FIFOs and the config regfile. Active only while raw mode is enabled.
// PARAMETERS
//  phy_data_t   serial_link_pkg::phy_data_t   raw phy word type (2*NumLanes bits, DDR)
//  NumChannels  serial_link_pkg::NumChannels  number of phy channels
//  CaptureDepth 8                             capture FIFO depth (>=2, power of two)
//  CntWidth     16                            width of capture length/counter
//  Log2NumChannels (local) = NumChannels>1 ? $clog2(NumChannels) : 1; Log2Depth (local) = $clog2(CaptureDepth)
// PORTS
//  clk_i                  in  1                 clock
//  rst_ni                 in  1                 asynchronous reset, active low
//  data_in_i              in  NumChannels x phy raw words from CDC RX FIFOs
//  data_in_valid_i        in  NumChannels       per-channel valid
//  data_in_ready_o        out NumChannels       per-channel ready (pop)
//  cfg_raw_mode_en_i      in  1                 raw mode enable; low forces Idle, all ready low
//  cfg_ch_sel_i           in  Log2NumChannels   channel to capture
//  cfg_drain_others_i     in  1                 1: pop (discard) valid words on non-selected channels
//  cfg_start_i            in  1                 pulse: start capture session
//  cfg_abort_i            in  1                 pulse: return to Idle
//  cfg_trig_en_i          in  1                 1: wait for pattern match before capturing
//  cfg_trig_pattern_i     in  phy               trigger pattern
//  cfg_trig_mask_i        in  phy               1 = bit compared
//  cfg_capture_len_i      in  CntWidth          words per session; 0 = unlimited
//  cfg_fifo_clear_i       in  1                 flush capture FIFO
//  cfg_data_o             out phy               FIFO head
//  cfg_data_valid_o       out 1                 FIFO non-empty
//  cfg_data_ready_i       in  1                 pop FIFO head when valid
//  cfg_fill_state_o       out Log2Depth+1       FIFO occupancy, exact 0..CaptureDepth
//  cfg_is_full_o          out 1                 FIFO full
//  cfg_state_o            out 2                 0 Idle, 1 Armed, 2 Capture, 3 Done
//  cfg_count_o            out CntWidth          words captured this session
// BEHAVIOUR
//  - Reset: state Idle, count 0, FIFO empty; outputs data_in_ready_o 0, cfg_data_o 0, valid 0, fill 0, full 0.
//  - sel_valid = data_in_valid_i[cfg_ch_sel_i]; word = data_in_i[cfg_ch_sel_i];
//    match = ((word ^ pattern) & mask) == 0.
//  - Non-selected channel ready = raw_en & cfg_drain_others_i & valid (discarded, never captured).
//  - Selected channel ready: Armed -> 1 (non-match discarded); Capture -> ~full; Idle/Done -> 0 (held in CDC FIFO).
//  - Transitions (evaluated with abort > raw_en low > start > data event):
//    any --abort or ~raw_en--> Idle (count kept until next start; no push this cycle).
//    Idle/Done --start--> Armed if trig_en else Capture; count := 0. Start in Armed/Capture restarts (count := 0).
//    Armed: sel_valid & match -> push word (ready=~full; if full, wait in Armed), count := 1,
//      -> Done if len==1 else Capture.
//    Capture: sel_valid & ~full -> push, count++; -> Done when count+1 == len (len != 0).
//    len == 0: capture until abort; count saturates at all-ones.
//  - Capture is lossless: full FIFO back-pressures the CDC FIFO, never drops words.
//  - FIFO: non-fall-through; word accepted in cycle N visible on cfg_data_o in N+1.
//    Push and pop in same cycle allowed when not full; when full, push refused in that cycle even if popping.
//  - cfg_fifo_clear_i: empties FIFO next cycle; push/pop in same cycle discarded; state/count unchanged.
//  - Pop with cfg_data_valid_o low: ignored. cfg_data_o = 0 when empty.
//  - State change on start is visible on cfg_state_o the next cycle; word accepted in start cycle is not captured.
// TESTING
//  1 No trigger, len=4, ch 2 streams 0x0001..0x0006 -> FIFO holds 1..4, state Done, count 4, ch2 ready low after 4th.
//  2 Trigger pattern 0xA5A5 mask 0xFFFF, stream 0x1111,0x2222,0xA5A5,0x3333, len 2 -> first two words dropped,
//    FIFO = A5A5,3333, Done.
//  3 len=0, Depth 8, no reads, 12 words offered -> 8 captured, full=1, fill=8, ready low; pop 3 -> next 3 words
//    accepted in order, none lost.
//  4 Abort mid-capture after 3 words -> state Idle next cycle, count 3, FIFO keeps 3 words, ready low.
//  5 drain_others=1, ch0/ch1 valid, sel=1 -> ch0 popped and discarded, only ch1 words in FIFO; drain_others=0 -> ch0 ready 0.
//  6 raw_en dropped during Armed, and clear asserted with simultaneous push -> Idle, all ready 0, FIFO empty, fill 0.

Source files
------------

// File: rtl/serial_link_raw_mode_capture.sv
// Raw-mode RX capture: pulls raw phy words from one selected channel into a readable FIFO,
// optionally starting at a masked trigger match. Capture never drops words; a full FIFO stalls the source.
module serial_link_raw_mode_capture #(
   parameter int NumChannels  = 4,
   parameter int PhyWidth     = 16,
   parameter int CaptureDepth = 8,
   parameter int CntWidth     = 16,
   localparam int Log2NumChannels = (NumChannels > 1) ? $clog2(NumChannels) : 1,
   localparam int Log2Depth       = $clog2(CaptureDepth)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NumChannels-1:0][PhyWidth-1:0]  data_in_i,
   input  logic [NumChannels-1:0]                data_in_valid_i,
   output logic [NumChannels-1:0]                data_in_ready_o,
   input  logic                                  cfg_raw_mode_en_i,
   input  logic [Log2NumChannels-1:0]            cfg_ch_sel_i,
   input  logic                                  cfg_drain_others_i,
   input  logic                                  cfg_start_i,
   input  logic                                  cfg_abort_i,
   input  logic                                  cfg_trig_en_i,
   input  logic [PhyWidth-1:0]                   cfg_trig_pattern_i,
   input  logic [PhyWidth-1:0]                   cfg_trig_mask_i,
   input  logic [CntWidth-1:0]                   cfg_capture_len_i,
   input  logic                                  cfg_fifo_clear_i,
   output logic [PhyWidth-1:0]                   cfg_data_o,
   output logic                                  cfg_data_valid_o,
   input  logic                                  cfg_data_ready_i,
   output logic [Log2Depth:0]                    cfg_fill_state_o,
   output logic                                  cfg_is_full_o,
   output logic [1:0]                            cfg_state_o,
   output logic [CntWidth-1:0]                   cfg_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [CntWidth-1:0]   r_count;
   logic [CntWidth-1:0]   w_count_next;
   logic [CntWidth-1:0]   w_count_inc;

   logic [PhyWidth-1:0]   r_mem [CaptureDepth];
   logic [Log2Depth-1:0]  r_wptr;
   logic [Log2Depth-1:0]  r_rptr;
   logic [Log2Depth:0]    r_fill;

   logic                  w_sel_valid;
   logic [PhyWidth-1:0]   w_word;
   logic                  w_match;
   logic                  w_full;
   logic                  w_valid;
   logic                  w_ctrl_block;
   logic                  w_sel_ready;
   logic                  w_take;
   logic                  w_push;
   logic                  w_pop;

   assign w_sel_valid = data_in_valid_i[cfg_ch_sel_i];
   assign w_word      = data_in_i[cfg_ch_sel_i];
   assign w_match     = ((w_word ^ cfg_trig_pattern_i) & cfg_trig_mask_i) == '0;
   assign w_full      = (r_fill == (Log2Depth+1)'(CaptureDepth));
   assign w_valid     = (r_fill != '0);
   assign w_count_inc = r_count + CntWidth'(1);

   // Control cycles never pop the selected channel, so no word is consumed and then thrown away.
   assign w_ctrl_block = cfg_abort_i | cfg_start_i | cfg_fifo_clear_i | ~cfg_raw_mode_en_i;

   always_comb begin
      w_sel_ready = 1'b0;
      if (!w_ctrl_block) begin
         case (r_state)
            ST_ARMED:   w_sel_ready = ~(w_match & w_full);
            ST_CAPTURE: w_sel_ready = ~w_full;
            default:    w_sel_ready = 1'b0;
         endcase
      end
   end

   assign w_take = w_sel_ready & w_sel_valid;
   assign w_push = w_take & ((r_state == ST_CAPTURE) | w_match);
   assign w_pop  = cfg_data_ready_i & w_valid & ~cfg_fifo_clear_i;

   generate
      for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ready
         assign data_in_ready_o[gi] = (cfg_ch_sel_i == Log2NumChannels'(gi)) ? w_sel_ready :
                                      (cfg_raw_mode_en_i & cfg_drain_others_i & data_in_valid_i[gi]);
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      if (cfg_abort_i || !cfg_raw_mode_en_i) begin
         w_state_next = ST_IDLE;
      end else if (cfg_start_i) begin
         w_state_next = cfg_trig_en_i ? ST_ARMED : ST_CAPTURE;
         w_count_next = '0;
      end else begin
         case (r_state)
            ST_ARMED: begin
               if (w_push) begin
                  w_count_next = CntWidth'(1);
                  w_state_next = (cfg_capture_len_i == CntWidth'(1)) ? ST_DONE : ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (w_push) begin
                  if (r_count != '1) w_count_next = w_count_inc;
                  // Length zero means run until abort; the counter then just saturates.
                  if ((cfg_capture_len_i != '0) && (w_count_inc == cfg_capture_len_i))
                     w_state_next = ST_DONE;
               end
            end
            default: begin
               w_state_next = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= w_word;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fill <= '0;
      end else if (cfg_fifo_clear_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fill <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + Log2Depth'(1);
         if (w_pop)  r_rptr <= r_rptr + Log2Depth'(1);
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + (Log2Depth+1)'(1);
            2'b01:   r_fill <= r_fill - (Log2Depth+1)'(1);
            default: r_fill <= r_fill;
         endcase
      end
   end

   assign cfg_data_o       = w_valid ? r_mem[r_rptr] : '0;
   assign cfg_data_valid_o = w_valid;
   assign cfg_fill_state_o = r_fill;
   assign cfg_is_full_o    = w_full;
   assign cfg_state_o      = r_state;
   assign cfg_count_o      = r_count;

endmodule

// File: tb/tb_serial_link_raw_mode_capture.sv
// Scoreboard bench: per-channel source queues model the CDC RX FIFOs; expected captured words
// are derived from the stream rules and checked by an independent FIFO read monitor.
module tb_serial_link_raw_mode_capture;

   localparam int NCH = 4;
   localparam int W   = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NCH-1:0][W-1:0] data_in;
   logic [NCH-1:0]        data_valid;
   logic [NCH-1:0]        data_ready;
   logic                  raw_en = 1'b1;
   logic [1:0]            ch_sel = '0;
   logic                  drain = 1'b0;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic                  trig_en = 1'b0;
   logic [W-1:0]          pattern = '0;
   logic [W-1:0]          mask = '0;
   logic [15:0]           cap_len = '0;
   logic                  fclear = 1'b0;
   logic [W-1:0]          rd_data;
   logic                  rd_valid;
   logic                  rd_ready = 1'b0;
   logic [3:0]            fill;
   logic                  full;
   logic [1:0]            state;
   logic [15:0]           count;

   serial_link_raw_mode_capture #(
      .NumChannels(NCH), .PhyWidth(W), .CaptureDepth(8), .CntWidth(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .data_in_i(data_in), .data_in_valid_i(data_valid), .data_in_ready_o(data_ready),
      .cfg_raw_mode_en_i(raw_en), .cfg_ch_sel_i(ch_sel), .cfg_drain_others_i(drain),
      .cfg_start_i(start), .cfg_abort_i(abort), .cfg_trig_en_i(trig_en),
      .cfg_trig_pattern_i(pattern), .cfg_trig_mask_i(mask), .cfg_capture_len_i(cap_len),
      .cfg_fifo_clear_i(fclear), .cfg_data_o(rd_data), .cfg_data_valid_o(rd_valid),
      .cfg_data_ready_i(rd_ready), .cfg_fill_state_o(fill), .cfg_is_full_o(full),
      .cfg_state_o(state), .cfg_count_o(count)
   );

   logic [W-1:0] src_q [NCH][$];
   logic [W-1:0] exp_q [$];
   int  n_cmp = 0;
   int  n_err = 0;
   bit  rd_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Source model: valid while the channel queue holds words, pop on handshake.
   initial begin
      logic [NCH-1:0] take;
      data_in = '0;
      data_valid = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < NCH; c++) begin
            data_valid[c] = (src_q[c].size() > 0);
            data_in[c]    = (src_q[c].size() > 0) ? src_q[c][0] : '0;
         end
         #1;
         take = data_valid & data_ready;
         @(posedge clk);
         for (int c = 0; c < NCH; c++)
            if (take[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rd_ready = rd_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Read monitor: every FIFO pop must match the oldest expected word.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_fifo_word", {16'h0, rd_data}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("fifo_data", {16'h0, rd_data}, {16'h0, e});
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sample_ready(output logic [NCH-1:0] r);
      @(negedge clk);
      #1;
      r = data_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1; tick(); abort = 1'b0;
   endtask

   task automatic prep();
      pulse_abort();
      for (int c = 0; c < NCH; c++) src_q[c].delete();
      fclear = 1'b1; tick(); fclear = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_count(input int n, input string name);
      int t = 0;
      while (count != 16'(n) && t < 200) begin tick(); t++; end
      if (t >= 200) chk({name, "_timeout"}, {16'h0, count}, n);
   endtask

   task automatic wait_exp_empty(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin tick(); t++; end
      if (t >= 500) chk({name, "_timeout"}, exp_q.size(), 0);
   endtask

   task automatic run_session(input int idx);
      int ch, trig, len, drn, extra, k;
      int n_other [NCH];
      logic [W-1:0] w;
      logic [NCH-1:0] r;
      logic [W-1:0] stream [$];
      int t;
      ch = $urandom_range(0, NCH-1); trig = $urandom_range(0, 1); len = $urandom_range(1, 12);
      drn = $urandom_range(0, 1); extra = $urandom_range(0, 3); k = trig ? $urandom_range(0, 4) : 0;
      prep();
      rd_en = 1'b1;
      ch_sel = 2'(ch); drain = 1'(drn); trig_en = 1'(trig); cap_len = 16'(len);
      pattern = W'($urandom); mask = W'($urandom) | 16'h0001;
      for (int i = 0; i < k; i++) begin
         do w = W'($urandom); while (((w ^ pattern) & mask) == '0);
         stream.push_back(w);
      end
      if (trig) stream.push_back((pattern & mask) | (W'($urandom) & ~mask));
      else      stream.push_back(W'($urandom));
      for (int i = 1; i < len + extra; i++) stream.push_back(W'($urandom));
      for (int i = 0; i < stream.size(); i++) begin
         src_q[ch].push_back(stream[i]);
         if (i >= k && i < k + len) exp_q.push_back(stream[i]);
      end
      for (int c = 0; c < NCH; c++) begin
         n_other[c] = (c == ch) ? 0 : $urandom_range(0, 5);
         for (int i = 0; i < n_other[c]; i++) src_q[c].push_back(W'($urandom));
      end
      tick(2);
      pulse_start();
      t = 0;
      while (!(state == 2'd3 && exp_q.size() == 0) && t < 1000) begin tick(); t++; end
      if (t >= 1000) chk("session_timeout", {30'h0, state}, 3);
      tick(3);
      chk("sess_state", {30'h0, state}, 3);
      chk("sess_count", {16'h0, count}, len);
      chk("sess_sel_left", src_q[ch].size(), extra);
      for (int c = 0; c < NCH; c++)
         if (c != ch) chk("sess_other_left", src_q[c].size(), drn ? 0 : n_other[c]);
      sample_ready(r);
      chk("sess_ready_after_done", {28'h0, r}, 0);
      $display("session %0d: ch=%0d trig=%0d len=%0d drop=%0d drain=%0d errors=%0d",
               idx, ch, trig, len, k, drn, n_err);
   endtask

   initial begin
      logic [NCH-1:0] r;
      int sz0, sz1, t;
      tick(2);
      chk("rst_state", {30'h0, state}, 0);
      chk("rst_count", {16'h0, count}, 0);
      chk("rst_fill", {28'h0, fill}, 0);
      chk("rst_full", {31'h0, full}, 0);
      chk("rst_valid", {31'h0, rd_valid}, 0);
      chk("rst_data", {16'h0, rd_data}, 0);
      chk("rst_ready", {28'h0, data_ready}, 0);
      rst_n = 1'b1;
      tick(2);

      for (int s = 0; s < 10; s++) run_session(s);

      // Full FIFO back-pressure with unlimited length, then lossless drain.
      prep();
      rd_en = 1'b0; ch_sel = 2'd3; drain = 1'b0; trig_en = 1'b0; cap_len = 16'd0;
      for (int i = 0; i < 12; i++) begin
         src_q[3].push_back(16'h0100 + 16'(i));
         exp_q.push_back(16'h0100 + 16'(i));
      end
      pulse_start();
      tick(20);
      chk("full_fill", {28'h0, fill}, 8);
      chk("full_flag", {31'h0, full}, 1);
      chk("full_src_left", src_q[3].size(), 4);
      sample_ready(r);
      chk("full_ready", {31'h0, r[3]}, 0);
      rd_en = 1'b1;
      wait_exp_empty("full_drain");
      tick(3);
      chk("full_count", {16'h0, count}, 12);
      chk("full_src_empty", src_q[3].size(), 0);
      $display("full test: errors=%0d", n_err);

      // Abort mid-capture keeps count and FIFO contents.
      prep();
      rd_en = 1'b0; ch_sel = 2'd0; cap_len = 16'd0;
      for (int i = 0; i < 3; i++) src_q[0].push_back(16'hB000 + 16'(i));
      pulse_start();
      wait_count(3, "abort_cap");
      tick();
      chk("abort_fill_before", {28'h0, fill}, 3);
      pulse_abort();
      chk("abort_state", {30'h0, state}, 0);
      chk("abort_count", {16'h0, count}, 3);
      chk("abort_fill", {28'h0, fill}, 3);
      src_q[0].push_back(16'hB100); src_q[0].push_back(16'hB101);
      tick(3);
      sample_ready(r);
      chk("abort_ready", {28'h0, r}, 0);
      chk("abort_src_held", src_q[0].size(), 2);
      for (int i = 0; i < 3; i++) exp_q.push_back(16'hB000 + 16'(i));
      rd_en = 1'b1;
      wait_exp_empty("abort_read");
      tick(2);
      chk("abort_fill_drained", {28'h0, fill}, 0);
      $display("abort test: errors=%0d", n_err);

      // FIFO clear with a word offered in the same cycle.
      prep();
      rd_en = 1'b0; ch_sel = 2'd1; cap_len = 16'd5;
      for (int i = 0; i < 3; i++) src_q[1].push_back(16'hC000 + 16'(i));
      pulse_start();
      wait_count(3, "clear_cap");
      tick();
      chk("clear_fill_before", {28'h0, fill}, 3);
      src_q[1].push_back(16'hC100); src_q[1].push_back(16'hC101);
      fclear = 1'b1; tick(); fclear = 1'b0;
      chk("clear_fill", {28'h0, fill}, 0);
      chk("clear_valid", {31'h0, rd_valid}, 0);
      chk("clear_data", {16'h0, rd_data}, 0);
      chk("clear_state", {30'h0, state}, 2);
      exp_q.push_back(16'hC100); exp_q.push_back(16'hC101);
      t = 0;
      while (state != 2'd3 && t < 100) begin tick(); t++; end
      chk("clear_done", {30'h0, state}, 3);
      chk("clear_count", {16'h0, count}, 5);
      rd_en = 1'b1;
      wait_exp_empty("clear_read");

      // Raw mode dropped while armed.
      prep();
      ch_sel = 2'd1; trig_en = 1'b1; pattern = 16'hA5A5; mask = 16'hFFFF; drain = 1'b1; cap_len = 16'd2;
      for (int i = 0; i < 20; i++) begin
         src_q[1].push_back(16'h1000 + 16'(i));
         src_q[0].push_back(16'h2000 + 16'(i));
      end
      pulse_start();
      tick(3);
      chk("armed_state", {30'h0, state}, 1);
      chk("armed_discard", (src_q[1].size() < 20) ? 1 : 0, 1);
      raw_en = 1'b0;
      tick();
      chk("rawoff_state", {30'h0, state}, 0);
      sz0 = src_q[0].size(); sz1 = src_q[1].size();
      tick(3);
      sample_ready(r);
      chk("rawoff_ready", {28'h0, r}, 0);
      chk("rawoff_src0", src_q[0].size(), sz0);
      chk("rawoff_src1", src_q[1].size(), sz1);
      chk("rawoff_fill", {28'h0, fill}, 0);
      raw_en = 1'b1;
      $display("clear/raw-off test: errors=%0d", n_err);
      prep();
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
